// File: rtl/parity_tx.sv
// -----------------------------------------------------------------------------
// parity_tx
//
// Serial transmitter that pairs with a serial parity checker. It takes one
// parallel word per valid/ready handshake and shifts it out LSB-first on
// ser_out. It then appends one parity bit, so the whole frame (data plus
// parity) carries even parity (PAR_ODD=0) or odd parity (PAR_ODD=1).
//
// Parameters
//   WIDTH    data word width, 2..32
//   PAR_ODD  0 = even-parity frames, 1 = odd-parity frames
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   data_in     word to transmit, captured only on an accepted handshake
//   valid_in    data_in is valid
//   ready_out   block can accept a word this cycle
//   ser_out     serial line: data bits LSB-first, then the parity bit
//   frame_out   high while ser_out carries a frame bit
//   par_out     high only while ser_out carries the parity bit
//   words_sent  count of completed frames, wraps at 16 bits
//
// Every output is a flop. The comb process works out next-cycle output values
// from the next state, so the outputs line up with the state register.
// -----------------------------------------------------------------------------
module parity_tx #(
    parameter int WIDTH   = 8,
    parameter bit PAR_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             ser_out,
    output logic             frame_out,
    output logic             par_out,
    output logic [15:0]      words_sent
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             acc_reg, acc_next;
    logic             ready_reg, ready_next;
    logic             ser_reg, ser_next;
    logic             frame_reg, frame_next;
    logic             par_reg, par_next;
    logic [15:0]      words_reg, words_next;
    logic             accept;

    // ready_reg is high exactly in IDLE and PARITY. That makes it the
    // handshake qualifier without decoding the state again.
    assign accept = valid_in & ready_reg;

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        words_next = words_reg;
        ready_next = 1'b1;
        ser_next   = 1'b0;
        frame_next = 1'b0;
        par_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = DATA;
                    shreg_next = data_in;
                    cnt_next   = '0;
                    acc_next   = 1'b0;
                    ready_next = 1'b0;
                    frame_next = 1'b1;
                    ser_next   = data_in[0];
                end
            end

            DATA: begin
                // shreg_reg[0] is the bit on the line this cycle. Parity is
                // accumulated from the bits actually sent, so a corrupted
                // shift register shows up at the checker.
                acc_next   = acc_reg ^ shreg_reg[0];
                shreg_next = {1'b0, shreg_reg[WIDTH-1:1]};
                cnt_next   = cnt_reg + CW'(1);
                frame_next = 1'b1;
                if (cnt_reg == LAST) begin
                    state_next = PARITY;
                    ready_next = 1'b1;
                    par_next   = 1'b1;
                    ser_next   = acc_next ^ PAR_ODD;
                end else begin
                    ready_next = 1'b0;
                    ser_next   = shreg_next[0];
                end
            end

            PARITY: begin
                words_next = words_reg + 16'd1;
                if (accept) begin
                    // A word taken during the parity bit starts the next
                    // frame right away, with no idle gap.
                    state_next = DATA;
                    shreg_next = data_in;
                    cnt_next   = '0;
                    acc_next   = 1'b0;
                    ready_next = 1'b0;
                    frame_next = 1'b1;
                    ser_next   = data_in[0];
                end else begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                shreg_next = '0;
                cnt_next   = '0;
                acc_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            cnt_reg   <= '0;
            acc_reg   <= 1'b0;
            ready_reg <= 1'b1;
            ser_reg   <= 1'b0;
            frame_reg <= 1'b0;
            par_reg   <= 1'b0;
            words_reg <= 16'd0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
            ready_reg <= ready_next;
            ser_reg   <= ser_next;
            frame_reg <= frame_next;
            par_reg   <= par_next;
            words_reg <= words_next;
        end
    end

    assign ready_out  = ready_reg;
    assign ser_out    = ser_reg;
    assign frame_out  = frame_reg;
    assign par_out    = par_reg;
    assign words_sent = words_reg;

endmodule

// File: tb/tb_parity_tx.sv
// -----------------------------------------------------------------------------
// tb_parity_tx
//
// Drives two transmitters: one even-parity instance and one odd-parity
// instance, both 8 bits wide. Each accepted word pushes its expected frame
// bits onto a queue. A negedge monitor pops those bits and compares them with
// ser_out/par_out. The scenario tasks also check handshake, timing and
// counter behaviour inline.
// -----------------------------------------------------------------------------
module tb_parity_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in, data_in_odd;
    logic        valid_in, valid_in_odd;
    logic        ready_out, ser_out, frame_out, par_out;
    logic        ready_out_odd, ser_out_odd, frame_out_odd, par_out_odd;
    logic [15:0] words_sent, words_sent_odd;

    int          checks = 0;
    int          passes = 0;
    logic [1:0]  q_even[$];
    logic [1:0]  q_odd[$];
    logic [1:0]  mon_e, mon_o;
    bit          mon_en = 1'b0;
    logic [15:0] exp_words = 16'd0;
    logic [15:0] exp_words_odd = 16'd0;

    always #5 clk = ~clk;

    parity_tx #(.WIDTH(8), .PAR_ODD(1'b0)) dut_even (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .ser_out(ser_out), .frame_out(frame_out),
        .par_out(par_out), .words_sent(words_sent)
    );

    parity_tx #(.WIDTH(8), .PAR_ODD(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .data_in(data_in_odd), .valid_in(valid_in_odd),
        .ready_out(ready_out_odd), .ser_out(ser_out_odd), .frame_out(frame_out_odd),
        .par_out(par_out_odd), .words_sent(words_sent_odd)
    );

    // Scoreboard monitor. Each entry is {is_parity_bit, line_value}.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (frame_out) begin
                if (q_even.size() == 0) begin
                    $display("FAIL mon_even_unexpected: frame bit ser=%b par=%b, required no frame", ser_out, par_out);
                end else begin
                    mon_e = q_even.pop_front();
                    if ({par_out, ser_out} !== mon_e)
                        $display("FAIL mon_even_bit: {par,ser}=%b required %b", {par_out, ser_out}, mon_e);
                    else
                        passes++;
                end
            end else if ({par_out, ser_out} !== 2'b00) begin
                $display("FAIL mon_even_idle: {par,ser}=%b required 00", {par_out, ser_out});
            end else begin
                passes++;
            end

            checks++;
            if (frame_out_odd) begin
                if (q_odd.size() == 0) begin
                    $display("FAIL mon_odd_unexpected: frame bit ser=%b par=%b, required no frame", ser_out_odd, par_out_odd);
                end else begin
                    mon_o = q_odd.pop_front();
                    if ({par_out_odd, ser_out_odd} !== mon_o)
                        $display("FAIL mon_odd_bit: {par,ser}=%b required %b", {par_out_odd, ser_out_odd}, mon_o);
                    else
                        passes++;
                end
            end else if ({par_out_odd, ser_out_odd} !== 2'b00) begin
                $display("FAIL mon_odd_idle: {par,ser}=%b required 00", {par_out_odd, ser_out_odd});
            end else begin
                passes++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input bit odd, input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            if (odd) q_odd.push_back({1'b0, d[i]});
            else     q_even.push_back({1'b0, d[i]});
        end
        if (odd) q_odd.push_back({1'b1, ~(^d)});
        else     q_even.push_back({1'b1, ^d});
    endtask

    // Offer d and return one cycle after acceptance, i.e. on data cycle 1.
    task automatic send(input bit odd, input logic [7:0] d);
        int n;
        n = 0;
        if (odd) begin valid_in_odd = 1'b1; data_in_odd = d; end
        else     begin valid_in     = 1'b1; data_in     = d; end
        while (((odd ? ready_out_odd : ready_out) !== 1'b1) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if ((odd ? ready_out_odd : ready_out) !== 1'b1) begin
            $display("FAIL send_timeout: ready=%b required 1 within 50 cycles", odd ? ready_out_odd : ready_out);
            valid_in = 1'b0;
            valid_in_odd = 1'b0;
            return;
        end
        passes++;
        push_frame(odd, d);
        if (odd) exp_words_odd++;
        else     exp_words++;
        tick();
        if (odd) valid_in_odd = 1'b0;
        else     valid_in     = 1'b0;
    endtask

    task automatic wait_idle(input bit odd);
        for (int n = 0; n < 40 && ((odd ? frame_out_odd : frame_out) !== 1'b0); n++)
            tick();
        checks++;
        if ((odd ? frame_out_odd : frame_out) !== 1'b0)
            $display("FAIL wait_idle_timeout: frame_out=%b required 0 within 40 cycles", odd ? frame_out_odd : frame_out);
        else
            passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_in = 1'b0; valid_in_odd = 1'b0;
        data_in = 8'h00; data_in_odd = 8'h00;
        tick();
        tick();
        checks++; if (ready_out !== 1'b1)      $display("FAIL reset_ready: ready_out=%b required 1", ready_out); else passes++;
        checks++; if (frame_out !== 1'b0)      $display("FAIL reset_frame: frame_out=%b required 0", frame_out); else passes++;
        checks++; if (ser_out !== 1'b0)        $display("FAIL reset_ser: ser_out=%b required 0", ser_out); else passes++;
        checks++; if (par_out !== 1'b0)        $display("FAIL reset_par: par_out=%b required 0", par_out); else passes++;
        checks++; if (words_sent !== 16'd0)    $display("FAIL reset_words: words_sent=%0d required 0", words_sent); else passes++;
        checks++; if (ready_out_odd !== 1'b1)  $display("FAIL reset_ready_odd: ready_out=%b required 1", ready_out_odd); else passes++;
        checks++; if (words_sent_odd !== 16'd0) $display("FAIL reset_words_odd: words_sent=%0d required 0", words_sent_odd); else passes++;
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_a5();
        send(1'b0, 8'hA5);
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (ready_out !== 1'b0) $display("FAIL a5_ready_cycle%0d: ready_out=%b required 0", k, ready_out); else passes++;
            tick();
        end
        checks++; if (par_out !== 1'b1)   $display("FAIL a5_par_flag: par_out=%b required 1", par_out); else passes++;
        checks++; if (ser_out !== 1'b0)   $display("FAIL a5_parity: ser_out=%b required 0", ser_out); else passes++;
        checks++; if (ready_out !== 1'b1) $display("FAIL a5_ready_parity: ready_out=%b required 1", ready_out); else passes++;
        tick();
        checks++; if (words_sent !== 16'd1) $display("FAIL a5_words: words_sent=%0d required 1", words_sent); else passes++;
        checks++; if (frame_out !== 1'b0)   $display("FAIL a5_frame_end: frame_out=%b required 0", frame_out); else passes++;
    endtask

    task automatic test_07();
        logic chk;
        chk = 1'b0;
        send(1'b0, 8'h07);
        for (int k = 1; k <= 9; k++) begin
            if (frame_out === 1'b1) chk ^= ser_out;
            if (k == 9) begin
                checks++;
                if ({par_out, ser_out} !== 2'b11) $display("FAIL x07_even_parity: {par,ser}=%b required 11", {par_out, ser_out}); else passes++;
            end
            tick();
        end
        checks++; if (chk !== 1'b0) $display("FAIL x07_even_checker: frame parity=%b required 0", chk); else passes++;
        checks++; if (words_sent !== exp_words) $display("FAIL x07_words: words_sent=%0d required %0d", words_sent, exp_words); else passes++;

        chk = 1'b0;
        send(1'b1, 8'h07);
        for (int k = 1; k <= 9; k++) begin
            if (frame_out_odd === 1'b1) chk ^= ser_out_odd;
            if (k == 9) begin
                checks++;
                if ({par_out_odd, ser_out_odd} !== 2'b10) $display("FAIL x07_odd_parity: {par,ser}=%b required 10", {par_out_odd, ser_out_odd}); else passes++;
            end
            tick();
        end
        checks++; if (chk !== 1'b1) $display("FAIL x07_odd_checker: frame parity=%b required 1", chk); else passes++;
        checks++; if (words_sent_odd !== exp_words_odd) $display("FAIL x07_words_odd: words_sent=%0d required %0d", words_sent_odd, exp_words_odd); else passes++;
    endtask

    task automatic test_back_to_back();
        int nhigh;
        nhigh = 0;
        valid_in = 1'b1;
        data_in = 8'h01;
        checks++; if (ready_out !== 1'b1) $display("FAIL b2b_ready_start: ready_out=%b required 1", ready_out); else passes++;
        push_frame(1'b0, 8'h01);
        exp_words++;
        tick();
        data_in = 8'hFF;
        push_frame(1'b0, 8'hFF);
        exp_words++;
        for (int k = 1; k <= 18; k++) begin
            if (k == 10) valid_in = 1'b0;
            if (frame_out === 1'b1) nhigh++;
            if (k == 9) begin
                checks++;
                if ({ready_out, par_out, ser_out} !== 3'b111) $display("FAIL b2b_first_parity: {ready,par,ser}=%b required 111", {ready_out, par_out, ser_out}); else passes++;
            end
            if (k == 18) begin
                checks++;
                if ({par_out, ser_out} !== 2'b10) $display("FAIL b2b_second_parity: {par,ser}=%b required 10", {par_out, ser_out}); else passes++;
            end
            tick();
        end
        checks++; if (nhigh != 18)          $display("FAIL b2b_frame_run: frame_out high %0d cycles required 18", nhigh); else passes++;
        checks++; if (frame_out !== 1'b0)   $display("FAIL b2b_frame_end: frame_out=%b required 0", frame_out); else passes++;
        checks++; if (words_sent !== exp_words) $display("FAIL b2b_words: words_sent=%0d required %0d", words_sent, exp_words); else passes++;
    endtask

    task automatic test_reset_mid();
        send(1'b0, 8'h3C);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        q_even.delete();
        q_odd.delete();
        exp_words = 16'd0;
        exp_words_odd = 16'd0;
        checks++; if (ser_out !== 1'b0)     $display("FAIL rmid_ser: ser_out=%b required 0", ser_out); else passes++;
        checks++; if (frame_out !== 1'b0)   $display("FAIL rmid_frame: frame_out=%b required 0", frame_out); else passes++;
        checks++; if (ready_out !== 1'b1)   $display("FAIL rmid_ready: ready_out=%b required 1", ready_out); else passes++;
        checks++; if (words_sent !== 16'd0) $display("FAIL rmid_words: words_sent=%0d required 0", words_sent); else passes++;
        rst = 1'b0;
        send(1'b0, 8'h80);
        for (int k = 1; k < 9; k++) tick();
        checks++; if ({par_out, ser_out} !== 2'b11) $display("FAIL rmid_x80_parity: {par,ser}=%b required 11", {par_out, ser_out}); else passes++;
        wait_idle(1'b0);
        checks++; if (words_sent !== 16'd1) $display("FAIL rmid_x80_words: words_sent=%0d required 1", words_sent); else passes++;
    endtask

    task automatic test_data_toggle();
        logic [7:0] d;
        for (int w = 0; w < 6; w++) begin
            d = 8'($urandom);
            send(1'b0, d);
            for (int k = 1; k <= 9; k++) begin
                data_in = 8'($urandom);
                tick();
            end
            wait_idle(1'b0);
        end
        checks++; if (words_sent !== exp_words) $display("FAIL toggle_words: words_sent=%0d required %0d", words_sent, exp_words); else passes++;
    endtask

    // Jump the frame counter to its last value rather than sending 65535
    // real frames, then let one real frame roll it over.
    task automatic test_wrap();
        force dut_even.words_reg = 16'hFFFF;
        tick();
        release dut_even.words_reg;
        tick();
        exp_words = 16'hFFFF;
        checks++; if (words_sent !== 16'hFFFF) $display("FAIL wrap_preload: words_sent=%h required ffff", words_sent); else passes++;
        send(1'b0, 8'h00);
        wait_idle(1'b0);
        checks++; if (words_sent !== exp_words) $display("FAIL wrap_words: words_sent=%h required %h", words_sent, exp_words); else passes++;
        checks++; if (words_sent !== 16'h0000)  $display("FAIL wrap_zero: words_sent=%h required 0000", words_sent); else passes++;
    endtask

    initial begin
        test_reset();
        test_a5();
        test_07();
        test_back_to_back();
        test_reset_mid();
        test_data_toggle();
        test_wrap();
        tick();
        tick();
        checks++; if (q_even.size() != 0) $display("FAIL drain_even: %0d expected bits left, required 0", q_even.size()); else passes++;
        checks++; if (q_odd.size() != 0)  $display("FAIL drain_odd: %0d expected bits left, required 0", q_odd.size()); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
